// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential 4x4 Vedic multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vedic_pkg;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PP   = 2'd1,
        DONE = 2'd2
    } state_e;

    // Left shift applied to each 2x2 partial product, indexed by idx:
    // lo*lo -> 0, hi*lo -> 2, lo*hi -> 2, hi*hi -> 4.
    function automatic logic [2:0] pp_shift(input logic [1:0] idx);
        logic [2:0] sh;
        sh = 3'd0;
        case (idx)
            2'd0: sh = 3'd0;
            2'd1: sh = 3'd2;
            2'd2: sh = 3'd2;
            2'd3: sh = 3'd4;
            default: sh = 3'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/vedic_2x2.sv
// Combinational 2x2 Vedic (Urdhva Tiryagbhyam) multiplier: AND gates plus two half adders.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a_i[1:0], b_i[1:0] unsigned operands; p_o[3:0] unsigned product.
module vedic_2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    logic cross0, cross1, hi;
    logic c1;

    assign cross0 = a_i[1] & b_i[0];
    assign cross1 = a_i[0] & b_i[1];
    assign hi     = a_i[1] & b_i[1];

    assign p_o[0] = a_i[0] & b_i[0];
    // First half adder sums the two crosswise terms.
    assign p_o[1] = cross0 ^ cross1;
    assign c1     = cross0 & cross1;
    // Second half adder folds that carry into the vertical high term.
    assign p_o[2] = hi ^ c1;
    assign p_o[3] = hi & c1;

endmodule

// File: rtl/vedic_mult4_seq.sv
// Sequential 4x4 Vedic multiplier: one 2x2 cell reused over four cycles into an 8-bit accumulator.
// Latency: 4 cycles from accept edge to out_valid; minimum initiation interval 6 cycles.
// Backpressure: product and out_valid hold in DONE until out_ready; in_ready is low while busy.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b; out_valid/out_ready with product; busy.
module vedic_mult4_seq
    import vedic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    generate
        if (N != OPW) begin : g_bad_width
            $fatal(1, "vedic_mult4_seq: only N=4 is supported");
        end
    endgenerate

    state_e             state_q;
    logic [OPW-1:0]     a_q, b_q;
    logic [1:0]         idx_q;
    logic [PRODW-1:0]   acc_q, acc_d;
    logic [PRODW-1:0]   product_q;
    logic               in_ready_q, out_valid_q, busy_q;

    logic [1:0]         cell_a, cell_b;
    logic [3:0]         cell_p;
    logic [PRODW-1:0]   pp_ext;

    // idx[0] picks the high half of a, idx[1] the high half of b.
    assign cell_a = idx_q[0] ? a_q[3:2] : a_q[1:0];
    assign cell_b = idx_q[1] ? b_q[3:2] : b_q[1:0];

    vedic_2x2 u_cell (
        .a_i (cell_a),
        .b_i (cell_b),
        .p_o (cell_p)
    );

    // Max total is 225, so the 8-bit sum never overflows.
    assign pp_ext = {4'b0000, cell_p};
    assign acc_d  = acc_q + (pp_ext << pp_shift(idx_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= PP;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                PP: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q     <= DONE;
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_vedic_mult4_seq.sv
module tb_vedic_mult4_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int n_chk;
    int n_err;

    vedic_mult4_seq #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation: accept, measure latency, optional stall in DONE, then handshake.
    task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] exp, input int hold, input bit inject);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_rdy"}, 16'(in_ready), 16'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        chk({tag, "_busy"}, 16'(busy), 16'd1);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, "_lat"}, 16'(lat), 16'd4);
        chk({tag, "_prod"}, 16'(product), 16'(exp));
        for (int i = 0; i < hold; i++) begin
            if (inject) begin
                in_valid = 1'b1;
                a        = 4'd3;
                b        = 4'd3;
            end
            step();
            chk({tag, "_hold_vld"}, 16'(out_valid), 16'd1);
            chk({tag, "_hold_prod"}, 16'(product), 16'(exp));
            chk({tag, "_hold_rdy"}, 16'(in_ready), 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_post_vld"}, 16'(out_valid), 16'd0);
        chk({tag, "_post_rdy"}, 16'(in_ready), 16'd1);
        chk({tag, "_post_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        logic [3:0] bb_a [4];
        logic [3:0] bb_b [4];
        logic [7:0] bb_p [4];
        int  sent, rcvd, cyc, last_cyc;
        bit  seen, pre_rdy, pre_vld, pre_ordy;
        logic [7:0] pre_prod;

        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_prod", 16'(product), 16'd0);
        chk("rst_vld", 16'(out_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        step();
        chk("rst_rdy", 16'(in_ready), 16'd1);

        run_op("m15x15", 4'd15, 4'd15, 8'hE1, 0, 1'b0);
        run_op("m0x13",  4'd0,  4'd13, 8'h00, 0, 1'b0);
        run_op("m1x1",   4'd1,  4'd1,  8'h01, 0, 1'b0);
        run_op("m9x6",   4'd9,  4'd6,  8'h36, 3, 1'b1);

        // Back-to-back: in_valid held high, out_ready high; one result per 6 cycles.
        bb_a = '{4'd5, 4'd7, 4'd10, 4'd14};
        bb_b = '{4'd3, 4'd8, 4'd11, 4'd2};
        bb_p = '{8'd15, 8'd56, 8'd110, 8'd28};
        sent = 0; rcvd = 0; cyc = 0; last_cyc = 0;
        in_valid  = 1'b1;
        a         = bb_a[0];
        b         = bb_b[0];
        out_ready = 1'b1;
        while (rcvd < 4 && cyc < 100) begin
            pre_rdy = in_ready;
            step();
            cyc++;
            if (pre_rdy && sent < 4) begin
                sent++;
                if (sent < 4) begin
                    a = bb_a[sent];
                    b = bb_b[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk($sformatf("b2b_prod%0d", rcvd), 16'(product), 16'(bb_p[rcvd]));
                if (rcvd > 0)
                    chk($sformatf("b2b_ii%0d", rcvd), 16'(cyc - last_cyc), 16'd6);
                last_cyc = cyc;
                rcvd++;
            end
        end
        chk("b2b_count", 16'(rcvd), 16'd4);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        // Reset in the middle of PP after idx1 has been accumulated.
        in_valid = 1'b1;
        a        = 4'd12;
        b        = 4'd11;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_prod", 16'(product), 16'd0);
        chk("mid_rst_vld", 16'(out_valid), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_rst_rdy", 16'(in_ready), 16'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | out_valid;
        end
        out_ready = 1'b0;
        chk("mid_rst_no_out", 16'(seen), 16'd0);
        run_op("m2x7", 4'd2, 4'd7, 8'h0E, 0, 1'b0);

        // Exhaustive sweep with random downstream backpressure.
        sent = 0; rcvd = 0; cyc = 0;
        in_valid = 1'b1;
        a        = 4'd0;
        b        = 4'd0;
        out_ready = 1'($urandom_range(0, 1));
        while (rcvd < 256 && cyc < 5000) begin
            pre_rdy  = in_ready;
            pre_vld  = out_valid;
            pre_ordy = out_ready;
            pre_prod = product;
            step();
            cyc++;
            if (pre_rdy && in_valid) begin
                sent++;
                if (sent < 256) begin
                    a = 4'(sent >> 4);
                    b = 4'(sent & 15);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (pre_vld && pre_ordy) begin
                chk($sformatf("exh_%0dx%0d", rcvd >> 4, rcvd & 15), 16'(pre_prod),
                    16'((rcvd >> 4) * (rcvd & 15)));
                rcvd++;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) rcvd++;
        end
        chk("exh_count", 16'(rcvd), 16'd256);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
